// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Pipeline hazard sequencer for the 5-stage MIPS core. Sits beside the ID
// stage and drives the PC / IF-ID enables, the IF/ID flush and the control
// bubble select (Check) feeding the ID/EX squash mux.
//
// Ports:
//   Clk, Rst_n        clock (rising edge), synchronous active-low reset
//   ID_Rs, ID_Rt      source register fields of the instruction in ID
//   ID_UsesRt         instruction in ID reads rt
//   EX_MemRead, EX_Rt load in EX and its destination register
//   Redirect          taken branch / jump resolved this cycle
//   MemBusy           data memory not ready, whole pipe holds
//   PCWrite, IFIDWrite, IFIDFlush, Check, PipeHold   hazard controls
//   State             FSM state (RUN=0, FLUSH=1, MEMWAIT=2)
//
// Optional feature macro: HAZARD_STATS_EN
//   Adds StallCount / FlushCount (32-bit saturating event counters).
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; load-use stalls handled here with no extra state
// FLUSH   | extra IF/ID flush cycles after a redirect (cnt remaining)
// MEMWAIT | data memory busy; everything held, resumes to ret state

module hazard_stall_unit #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_Rt,
    input  logic       Redirect,
    input  logic       MemBusy,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFIDFlush,
    output logic       Check,
    output logic       PipeHold,
    output logic [1:0] State
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     r_state;
    state_t     r_ret;
    logic [2:0] r_cnt;

    state_t     w_state_nxt;
    state_t     w_ret_nxt;
    logic [2:0] w_cnt_nxt;
    logic       w_load_use;
    logic       w_stall;
    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_ifid_flush;
    logic       w_check;
    logic       w_pipe_hold;

    // $zero is never a real dependency, so a load into r0 cannot stall.
    assign w_load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                        ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    always_comb begin
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_check      = 1'b0;
        w_pipe_hold  = 1'b0;
        w_stall      = 1'b0;
        w_state_nxt  = r_state;
        w_ret_nxt    = r_ret;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            ST_RUN: begin
                if (MemBusy) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_pipe_hold  = 1'b1;
                    w_state_nxt  = ST_MEMWAIT;
                    w_ret_nxt    = ST_RUN;
                end else if (Redirect) begin
                    // Redirect beats load-use: the dependent instruction is squashed anyway.
                    w_ifid_flush = 1'b1;
                    w_check      = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_cnt_nxt   = CNT_RELOAD;
                        w_state_nxt = ST_FLUSH;
                    end
                end else if (w_load_use) begin
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_check      = 1'b1;
                    w_stall      = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (MemBusy) begin
                    // cnt frozen so the flush resumes where it left off.
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_pipe_hold  = 1'b1;
                    w_state_nxt  = ST_MEMWAIT;
                    w_ret_nxt    = ST_FLUSH;
                end else begin
                    w_ifid_flush = 1'b1;
                    w_check      = 1'b1;
                    if (Redirect) begin
                        w_cnt_nxt = CNT_RELOAD;
                    end else if (r_cnt <= 3'd1) begin
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
            end
            ST_MEMWAIT: begin
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                w_pipe_hold  = 1'b1;
                if (!MemBusy) begin
                    w_state_nxt = r_ret;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Reset forces a safe squash pattern regardless of the state held.
        if (!Rst_n) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_ifid_flush = 1'b1;
            w_check      = 1'b1;
            w_pipe_hold  = 1'b0;
            w_stall      = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= ST_RUN;
            r_ret   <= ST_RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign PCWrite   = w_pc_write;
    assign IFIDWrite = w_ifid_write;
    assign IFIDFlush = w_ifid_flush;
    assign Check     = w_check;
    assign PipeHold  = w_pipe_hold;
    assign State     = Rst_n ? r_state : ST_RUN;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (w_ifid_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign StallCount = r_stall_count;
    assign FlushCount = r_flush_count;
`endif

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline hazard sequencer for the 5-stage MIPS core. Detects load-use hazards, taken branches/jumps, and multi-cycle data-memory waits, and drives the PC/IF-ID write enables, the IF/ID flush, and the `Check` bubble-select that zeroes ID-stage control signals before they enter ID/EX. Sits beside the ID stage. Its outputs feed the PC register, the IF/ID pipeline register and the control-squash mux.

## Interface
- `FLUSH_CYCLES`, default 1: IF/ID flush cycles per redirect. Legal range 1–7.
- `Clk` in 1: single clock, rising edge.
- `Rst_n` in 1: reset, synchronous, active-low.
- `ID_Rs` in 5: rs field of the instruction in ID.
- `ID_Rt` in 5: rt field of the instruction in ID.
- `ID_UsesRt` in 1: instruction in ID reads rt as a source.
- `EX_MemRead` in 1: the instruction in EX is a load.
- `EX_Rt` in 5: destination register of the load in EX.
- `Redirect` in 1: branch taken or jump/jal/jr resolved this cycle.
- `MemBusy` in 1: data memory not ready; the whole pipe must hold.
- `PCWrite` out 1: PC update enable.
- `IFIDWrite` out 1: IF/ID register load enable.
- `IFIDFlush` out 1: clear IF/ID to a nop.
- `Check` out 1: 1 selects all-zero control into ID/EX (bubble).
- `PipeHold` out 1: freeze ID/EX, EX/MEM and MEM/WB.
- `State` out 2: FSM state. RUN=0, FLUSH=1, MEMWAIT=2.

## Operation
- **LoadUse** = `EX_MemRead` & `EX_Rt`≠0 & (`EX_Rt`==`ID_Rs` | (`ID_UsesRt` & `EX_Rt`==`ID_Rt`)).
- **Default outputs:** `PCWrite`=1, `IFIDWrite`=1, `IFIDFlush`=0, `Check`=0, `PipeHold`=0.
- **Priority in every state:** `MemBusy` > `Redirect` > LoadUse.
- **RUN:**
  - `MemBusy`: `PCWrite`=0, `IFIDWrite`=0, `PipeHold`=1. Next state MEMWAIT with ret=RUN.
  - else `Redirect`: `IFIDFlush`=1 and `Check`=1. If `FLUSH_CYCLES`>1, load cnt=`FLUSH_CYCLES`-1 and go to FLUSH. Otherwise stay in RUN.
  - else LoadUse: `PCWrite`=0, `IFIDWrite`=0, `Check`=1. Stay in RUN. The stall re-evaluates each cycle with no extra state.
- **FLUSH:**
  - `IFIDFlush`=1, `Check`=1, `PCWrite`=1.
  - cnt decrements each cycle. When cnt==1, go to RUN.
  - `MemBusy` in FLUSH: hold outputs as in MEMWAIT, freeze cnt, go to MEMWAIT with ret=FLUSH.
  - `Redirect` in FLUSH reloads cnt=`FLUSH_CYCLES`-1.
  - LoadUse is ignored in FLUSH because the ID instruction is being squashed.
- **MEMWAIT:**
  - `PCWrite`=0, `IFIDWrite`=0, `PipeHold`=1, `Check`=0, `IFIDFlush`=0, unconditionally.
  - When `MemBusy`=0, go to ret. This gives exactly one release cycle after `MemBusy` falls.
  - `Redirect`/LoadUse are not evaluated in MEMWAIT.
- **Simultaneous `Redirect` + LoadUse:** redirect wins. No stall cycle is spent.
- **`State` encoding 3** is unreachable. If entered, go to RUN next cycle with default outputs.

## Timing
- **Reset:** `Rst_n`=0 at an edge gives next-cycle state=RUN, cnt=0, ret=RUN.
  - While `Rst_n`=0, outputs are forced: `PCWrite`=0, `IFIDWrite`=0, `IFIDFlush`=1, `Check`=1, `PipeHold`=0, `State`=0.
  - Applies mid-FLUSH or mid-MEMWAIT too, with no residue. This resolves the conflict with the RUN defaults.
- **Output timing:**
  - Outputs are combinational from the registered state plus the current-cycle inputs.
  - Hazard response has zero-cycle latency: the stall or flush takes effect at the same edge the hazard is seen.
  - State, cnt and ret are registered.
- **LoadUse stall:** exactly 1 cycle per load-use pair. The next cycle EX holds the bubble, so LoadUse deasserts.
- **Redirect:** `IFIDFlush` is high for exactly `FLUSH_CYCLES` consecutive cycles, not counting MEMWAIT cycles.
- **`MemBusy` high for N cycles:** `PipeHold` is high for N+1 cycles. This covers the entry cycle in RUN or FLUSH, then the MEMWAIT cycles through the release cycle.

## Configuration
- **`HAZARD_STATS_EN` defined:**
  - Adds `StallCount` out 32, counting LoadUse stall cycles.
  - Adds `FlushCount` out 32, counting cycles with `IFIDFlush`=1 outside reset.
  - Both saturate at 32'hFFFFFFFF, clear on reset, and increment at the edge ending the counted cycle.
- **Undefined:** the ports and the counters are absent. All other behaviour is identical.

## Test plan
- **Load-use:** `EX_MemRead`=1, `EX_Rt`=8, `ID_Rs`=8 → for 1 cycle `PCWrite`=0, `IFIDWrite`=0, `Check`=1. Next cycle with `EX_MemRead`=0, defaults return.
- **Register 0:** `EX_Rt`=0=`ID_Rs` with `EX_MemRead`=1 → no stall. Separately, `ID_UsesRt`=0 and `ID_Rt`=`EX_Rt`=9 → no stall.
- **Redirect flush:** `FLUSH_CYCLES`=3, `Redirect` pulse → `IFIDFlush`=1 for 3 cycles with `State` 0,1,1, then RUN. A LoadUse input during those cycles produces no stall.
- **Memory wait:** `MemBusy` high for 4 cycles in RUN → `PipeHold`=1 for 5 cycles, `State`=2 for 4 cycles, then RUN.
- **Memory wait inside flush:** `MemBusy` high for 2 cycles during FLUSH with cnt=2 → state returns to FLUSH, cnt resumes at 2, and total `IFIDFlush` cycles equal `FLUSH_CYCLES`.
- **Reset mid-operation:** `Rst_n`=0 during MEMWAIT → next cycle `State`=0. With `HAZARD_STATS_EN` defined, `StallCount`=`FlushCount`=0.
